// File: rtl/wb_regfile.sv
// Writeback-stage register file: decodes the MEM/WB instruction, aligns load data, writes 31 GPRs.
// Latency: wb_* and rd* are combinational (write-before-read bypass); state commits on the next clk edge.
// Backpressure: none; one instruction is retired every cycle.
module wb_regfile #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         MEM_WB_instr,
    input  logic [31:0]         DataMem_MEM_WB_r,
    input  logic [31:0]         ALUOut_MEM_WB_r,
    input  logic [4:0]          WriteDst_MEM_WB_r,
    input  logic [4:0]          ra1,
    input  logic [4:0]          ra2,
    output logic [31:0]         rd1,
    output logic [31:0]         rd2,
    output logic                wb_we,
    output logic [4:0]          wb_addr,
    output logic [31:0]         wb_data,
    output logic                align_err,
    output logic [RETIRE_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        LD_NONE,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU,
        LD_W
    } ld_kind_t;

    typedef struct packed {
        logic     wr;
        ld_kind_t ld;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    dec_t        dec;
    logic [1:0]  a;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        misaligned;
    logic        bypass;
    logic [31:0] regs [1:31];

    assign a = ALUOut_MEM_WB_r[1:0];

    always_comb begin
        dec = '{wr: 1'b0, ld: LD_NONE};
        case (MEM_WB_instr[31:26])
            OP_RTYPE: dec.wr = (MEM_WB_instr[5:0] != FN_JR);
            OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dec.wr = 1'b1;
            OP_LB:  dec = '{wr: 1'b1, ld: LD_B};
            OP_LBU: dec = '{wr: 1'b1, ld: LD_BU};
            OP_LH:  dec = '{wr: 1'b1, ld: LD_H};
            OP_LHU: dec = '{wr: 1'b1, ld: LD_HU};
            OP_LW:  dec = '{wr: 1'b1, ld: LD_W};
            default: ;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    always_comb begin
        case (a)
            2'd0:    ld_byte = DataMem_MEM_WB_r[31:24];
            2'd1:    ld_byte = DataMem_MEM_WB_r[23:16];
            2'd2:    ld_byte = DataMem_MEM_WB_r[15:8];
            default: ld_byte = DataMem_MEM_WB_r[7:0];
        endcase
        ld_half = a[1] ? DataMem_MEM_WB_r[15:0] : DataMem_MEM_WB_r[31:16];
        case (dec.ld)
            LD_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_val = {24'd0, ld_byte};
            LD_H:    ld_val = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_val = {16'd0, ld_half};
            default: ld_val = DataMem_MEM_WB_r;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if ((dec.ld == LD_H || dec.ld == LD_HU) && a[0]) begin
            misaligned = 1'b1;
        end
        if (dec.ld == LD_W && a != 2'd0) begin
            misaligned = 1'b1;
        end
    end

    assign wb_we   = dec.wr && !misaligned && (WriteDst_MEM_WB_r != 5'd0);
    assign wb_addr = WriteDst_MEM_WB_r;
    assign wb_data = (dec.ld == LD_NONE) ? ALUOut_MEM_WB_r : ld_val;

    // No bypass while in reset: the write cannot land, so readers see the cleared file.
    assign bypass = wb_we && rst;

    always_comb begin
        rd1 = '0;
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end else if (bypass && ra1 == wb_addr) begin
            rd1 = wb_data;
        end else begin
            rd1 = regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 == 5'd0) begin
            rd2 = '0;
        end else if (bypass && ra2 == wb_addr) begin
            rd2 = wb_data;
        end else begin
            rd2 = regs[ra2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i[4:0]] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
            align_err  <= 1'b0;
        end else begin
            if (MEM_WB_instr != 32'h0) begin
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
            if (misaligned) begin
                align_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed instruction stream, checked every cycle against a behavioural model
// plus hand-computed literal expectations.
module tb_wb_regfile;

    localparam int RW = 4;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_ADDI  = 32'h2005_1234;
    localparam logic [31:0] I_ADD   = 32'h00A6_2020;
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_SW    = 32'hAC05_0000;
    localparam logic [31:0] I_LB    = 32'h8006_0000;
    localparam logic [31:0] I_LH    = 32'h8409_0000;
    localparam logic [31:0] I_LW    = 32'h8C05_0000;
    localparam logic [31:0] I_LBU   = 32'h9008_0000;
    localparam logic [31:0] I_LHU   = 32'h940A_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   MEM_WB_instr = '0;
    logic [31:0]   DataMem_MEM_WB_r = '0;
    logic [31:0]   ALUOut_MEM_WB_r = '0;
    logic [4:0]    WriteDst_MEM_WB_r = '0;
    logic [4:0]    ra1 = '0;
    logic [4:0]    ra2 = '0;
    logic [31:0]   rd1, rd2, wb_data;
    logic          wb_we, align_err;
    logic [4:0]    wb_addr;
    logic [RW-1:0] retire_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_regs [0:31];
    int          m_cnt = 0;
    bit          m_err = 1'b0;

    wb_regfile #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst),
        .MEM_WB_instr(MEM_WB_instr), .DataMem_MEM_WB_r(DataMem_MEM_WB_r),
        .ALUOut_MEM_WB_r(ALUOut_MEM_WB_r), .WriteDst_MEM_WB_r(WriteDst_MEM_WB_r),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .align_err(align_err), .retire_cnt(retire_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Effective write from the instruction rules: a load of N bytes is misaligned when the
    // offset is not a multiple of N; load lanes are picked by shifting the chosen bytes to the top.
    function automatic void predict(input logic [31:0] instr, input logic [31:0] alu,
                                    input logic [31:0] dmem, input logic [4:0] dst,
                                    output logic we, output logic [31:0] data, output logic mis);
        int op;
        int off;
        int size;
        bit wr;
        bit ld;
        bit sgn;
        logic [31:0] sh;
        logic signed [31:0] ssh;
        op = int'(instr[31:26]);
        off = int'(alu[1:0]);
        size = 4;
        wr = 1'b0;
        ld = 1'b0;
        sgn = 1'b0;
        if (op == 0) wr = (instr[5:0] != 6'h08);
        else if (op == 3 || (op >= 8 && op <= 15)) wr = 1'b1;
        case (op)
            32: begin ld = 1'b1; size = 1; sgn = 1'b1; end
            33: begin ld = 1'b1; size = 2; sgn = 1'b1; end
            35: begin ld = 1'b1; size = 4; end
            36: begin ld = 1'b1; size = 1; end
            37: begin ld = 1'b1; size = 2; end
            default: ;
        endcase
        mis = ld && (off % size != 0);
        sh = dmem << (8 * off);
        ssh = sh;
        if (!ld) data = alu;
        else if (size == 4) data = dmem;
        else if (sgn) data = ssh >>> (32 - 8 * size);
        else data = sh >> (32 - 8 * size);
        we = (wr || ld) && !mis && (dst != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic we, input logic [31:0] data);
        if (ra == 5'd0) return 32'h0;
        if (we && rst && ra == WriteDst_MEM_WB_r) return data;
        return m_regs[ra];
    endfunction

    always @(posedge clk or negedge rst) begin
        logic we;
        logic mis;
        logic [31:0] data;
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] <= 32'h0;
            m_cnt <= 0;
            m_err <= 1'b0;
        end else begin
            predict(MEM_WB_instr, ALUOut_MEM_WB_r, DataMem_MEM_WB_r, WriteDst_MEM_WB_r, we, data, mis);
            if (we) m_regs[WriteDst_MEM_WB_r] <= data;
            if (mis) m_err <= 1'b1;
            if (MEM_WB_instr != 32'h0) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic we;
        logic mis;
        logic [31:0] data;
        if (cmp_en) begin
            predict(MEM_WB_instr, ALUOut_MEM_WB_r, DataMem_MEM_WB_r, WriteDst_MEM_WB_r, we, data, mis);
            chk("model wb_we", 32'(wb_we), 32'(we));
            chk("model wb_addr", 32'(wb_addr), 32'(WriteDst_MEM_WB_r));
            if (we) chk("model wb_data", wb_data, data);
            chk("model rd1", rd1, exp_rd(ra1, we, data));
            chk("model rd2", rd2, exp_rd(ra2, we, data));
            chk("model retire_cnt", 32'(retire_cnt), 32'(m_cnt % (1 << RW)));
            chk("model align_err", 32'(align_err), 32'(m_err));
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] dmem,
                         input logic [4:0] dst, input logic [4:0] r1, input logic [4:0] r2);
        MEM_WB_instr = instr;
        ALUOut_MEM_WB_r = alu;
        DataMem_MEM_WB_r = dmem;
        WriteDst_MEM_WB_r = dst;
        ra1 = r1;
        ra2 = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset retire_cnt", 32'(retire_cnt), 32'h0);
        chk("reset align_err", 32'(align_err), 32'h0);
        chk("reset rd1", rd1, 32'h0);
        rst = 1'b1;

        drive(I_ADDI, 32'h0000_1234, 32'h0, 5'd5, 5'd5, 5'd0);
        chk("addi wb_we", 32'(wb_we), 32'h1);
        chk("addi bypass rd1", rd1, 32'h0000_1234);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        chk("addi reg rd1", rd1, 32'h0000_1234);
        chk("addi retire_cnt", 32'(retire_cnt), 32'h1);
        chk("nop wb_we", 32'(wb_we), 32'h0);
        tick();

        drive(I_LB, 32'h0000_1000, 32'h80FF_7F01, 5'd6, 5'd0, 5'd0);
        chk("lb a0", wb_data, 32'hFFFF_FF80);
        tick();
        drive(I_LB, 32'h0000_1002, 32'h80FF_7F01, 5'd7, 5'd6, 5'd0);
        chk("lb a2", wb_data, 32'h0000_007F);
        chk("lb a0 reg", rd1, 32'hFFFF_FF80);
        tick();
        drive(I_LBU, 32'h0000_1000, 32'h80FF_7F01, 5'd8, 5'd0, 5'd0);
        chk("lbu a0", wb_data, 32'h0000_0080);
        tick();
        drive(I_LH, 32'h0000_1002, 32'h1234_8001, 5'd9, 5'd0, 5'd0);
        chk("lh a2", wb_data, 32'hFFFF_8001);
        tick();
        drive(I_LHU, 32'h0000_1002, 32'h1234_8001, 5'd10, 5'd9, 5'd10);
        chk("lhu a2", wb_data, 32'h0000_8001);
        chk("lh reg rd1", rd1, 32'hFFFF_8001);
        chk("lhu bypass rd2", rd2, 32'h0000_8001);
        tick();

        drive(I_LW, 32'h0000_0006, 32'hCAFE_F00D, 5'd5, 5'd5, 5'd0);
        chk("lw mis wb_we", 32'(wb_we), 32'h0);
        chk("lw mis rd1", rd1, 32'h0000_1234);
        chk("lw pre align_err", 32'(align_err), 32'h0);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        chk("lw mis reg", rd1, 32'h0000_1234);
        chk("lw align_err set", 32'(align_err), 32'h1);
        chk("lw retire_cnt", 32'(retire_cnt), 32'h7);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        chk("align_err sticky", 32'(align_err), 32'h1);
        chk("nop no count", 32'(retire_cnt), 32'h7);
        tick();

        drive(I_SW, 32'h0000_0055, 32'h0, 5'd5, 5'd0, 5'd0);
        chk("sw wb_we", 32'(wb_we), 32'h0);
        tick();
        drive(I_JR, 32'h0000_0066, 32'h0, 5'd5, 5'd0, 5'd0);
        chk("jr wb_we", 32'(wb_we), 32'h0);
        tick();
        drive(I_ADDI, 32'h0000_ABCD, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("addi r0 wb_we", 32'(wb_we), 32'h0);
        chk("addi r0 rd1", rd1, 32'h0);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
        chk("r0 stays 0", rd1, 32'h0);
        chk("r5 unchanged", rd2, 32'h0000_1234);
        chk("sw jr count", 32'(retire_cnt), 32'd10);
        tick();

        drive(I_JAL, 32'hDEAD_BEEF, 32'h0, 5'd31, 5'd0, 5'd0);
        chk("jal wb_we", 32'(wb_we), 32'h1);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd31, 5'd0);
        chk("jal reg", rd1, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        chk("rst pulse rd1", rd1, 32'h0);
        chk("rst pulse retire_cnt", 32'(retire_cnt), 32'h0);
        chk("rst pulse align_err", 32'(align_err), 32'h0);
        rst = 1'b1;
        tick();

        drive(I_ADD, 32'h0000_0077, 32'h0, 5'd3, 5'd3, 5'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        chk("held rst no write", rd1, 32'h0);
        chk("held rst no count", 32'(retire_cnt), 32'h0);
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(I_ADD, 32'(i + 1), 32'h0, 5'd3, 5'd3, 5'd0);
            if (i == 15) chk("cnt at 15", 32'(retire_cnt), 32'd15);
            tick();
        end
        drive(I_NOP, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        chk("cnt wrap", 32'(retire_cnt), 32'h0);
        chk("last add reg", rd1, 32'd16);
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port MEM_WB_instr, input, 32: instruction in the WB stage.
REQ-005 SHALL have port DataMem_MEM_WB_r, input, 32: load data word read from data memory.
REQ-006 SHALL have port ALUOut_MEM_WB_r, input, 32: ALU result, or the effective address for loads, or the link value for jal.
REQ-007 SHALL have port WriteDst_MEM_WB_r, input, 5: destination register number.
REQ-008 SHALL have ports ra1 and ra2, input, 5 each: read addresses.
REQ-009 SHALL have ports rd1 and rd2, output, 32 each: read data.
REQ-010 SHALL have ports wb_we (output, 1), wb_addr (output, 5) and wb_data (output, 32): the effective write this cycle.
REQ-011 SHALL have port align_err, output, 1: sticky flag for a misaligned load.
REQ-012 SHALL have port retire_cnt, output, RETIRE_W: count of retired non-NOP instructions.

Function
REQ-013 SHALL decode op = instr[31:26] as follows.
- Write-enable set: R-type (op 000000) except funct 001000 (jr); addi, addiu, slti, sltiu, andi, ori, xori, lui; jal (000011); loads lb, lh, lw, lbu, lhu.
- All other opcodes: no write.
REQ-014 SHALL take wb_data from ALUOut for all non-load writes.
REQ-015 SHALL extract load data big-endian, with a = ALUOut[1:0].
- lw: full word.
- lb/lbu: byte a; a=0 selects bits [31:24].
- lh/lhu: a[1]=0 selects bits [31:16]; a[1]=1 selects bits [15:0].
- lb/lh sign-extend; lbu/lhu zero-extend.
REQ-016 SHALL treat lh/lhu with a[0]=1, or lw with a!=0, as misaligned.
- No register write.
- align_err set to 1 on the next edge.
REQ-017 SHALL drive wb_we = decoded write-enable AND not misaligned AND WriteDst!=0; wb_addr = WriteDst; wb_data as selected. These outputs are combinational.
REQ-018 SHALL write wb_data into register wb_addr on the rising edge when wb_we=1.
REQ-019 SHALL hold register 0 at zero; writes to it are discarded.
REQ-020 SHALL return reg[raN] on rdN combinationally, with these overrides:
- raN=0 returns 0.
- raN==wb_addr with wb_we=1 returns wb_data in the same cycle (write-before-read bypass).
REQ-021 SHALL increment retire_cnt by 1 on each edge where MEM_WB_instr != 32'h0, including non-writing and misaligned instructions.
REQ-022 SHALL wrap retire_cnt modulo 2^RETIRE_W.
REQ-023 SHALL keep align_err at 1 until reset.
REQ-024 SHALL perform all of the following on the same edge, independently: register write, counter update, align_err update.

Reset
REQ-025 SHALL, on rst=0 and without waiting for clk, clear all 31 registers to 0, retire_cnt to 0 and align_err to 0.
REQ-026 SHALL suppress register writes and counter increments on any edge where rst=0, including a reset asserted in the middle of an instruction stream.
REQ-027 SHALL, while rst=0, still drive rd1/rd2/wb_* combinationally; rd1/rd2 return 0 from the cleared registers.
REQ-028 SHALL resume normal updates on the first rising clk edge after rst returns to 1.

Verification
REQ-029 SHALL check addi to $5 with ALUOut=0x0000_1234, then ra1=5.
- Same cycle: wb_we=1 and rd1=0x1234 through the bypass.
- Next cycle: rd1=0x1234 from the register.
- retire_cnt=1.
REQ-030 SHALL check lb with DataMem=0x80FF_7F01: a=0 -> 0xFFFF_FF80; a=2 -> 0x0000_007F; lbu with a=0 -> 0x0000_0080.
REQ-031 SHALL check lh with a=2 and DataMem=0x1234_8001 -> 0xFFFF_8001, and lhu with a=2 -> 0x0000_8001.
REQ-032 SHALL check lw with ALUOut=0x0000_0006:
- No write; register unchanged.
- align_err=1 from the next cycle and stays 1.
- retire_cnt still increments.
REQ-033 SHALL check the following give wb_we=0 with no register change:
- instr=0x0000_0000: retire_cnt unchanged.
- sw and jr: retire_cnt increments.
- addi to $0: rd1 for ra1=0 stays 0.
REQ-034 SHALL check reset behaviour.
- Write 0xDEAD_BEEF to $31, then pulse rst low between edges: rd for $31 reads 0 immediately; retire_cnt=0; align_err=0.
- With RETIRE_W=4: sixteen non-NOP instructions wrap retire_cnt from 15 to 0.
